// File: rtl/color_centroid.sv
// color_centroid: classifies each captured RGB444 pixel against a colour threshold,
// forwards a filtered copy of the write stream and computes the per-frame centroid
// of matching pixels with a restoring divider.
// Optional build macro CENTROID_MARK_EN overlays a crosshair at the last valid centroid.
module color_centroid #(
    parameter int unsigned c_img_cols     = 160,
    parameter int unsigned c_img_rows     = 120,
    parameter int unsigned c_img_pxls     = c_img_cols * c_img_rows,
    parameter int unsigned c_nb_line_pxls = $clog2(c_img_cols),
    parameter int unsigned c_nb_row       = $clog2(c_img_rows),
    parameter int unsigned c_nb_img_pxls  = $clog2(c_img_pxls),
    parameter int unsigned c_nb_sum       = c_nb_img_pxls + c_nb_line_pxls,
    parameter int unsigned c_min_pxls     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                color_sel,
    input  logic [3:0]                thr_hi,
    input  logic [3:0]                thr_lo,
    input  logic [c_nb_img_pxls-1:0]  pxl_addr,
    input  logic [11:0]               pxl_data,
    input  logic                      pxl_we,
    output logic [c_nb_img_pxls-1:0]  out_addr,
    output logic [11:0]               out_data,
    output logic                      out_we,
    output logic [c_nb_line_pxls-1:0] cx,
    output logic [c_nb_row-1:0]       cy,
    output logic [c_nb_img_pxls-1:0]  pxl_count,
    output logic                      centroid_valid,
    output logic                      centroid_upd
);

    localparam int unsigned BitW = $clog2(c_nb_sum);
    localparam logic [c_nb_img_pxls-1:0] Cols     = c_nb_img_pxls'(c_img_cols);
    localparam logic [c_nb_img_pxls-1:0] LastAddr = c_nb_img_pxls'(c_img_pxls - 1);

    typedef enum logic [1:0] {StAccum, StDivX, StDivY, StPublish} state_e;

    state_e state_q, state_d;

    logic [3:0] lvl_r, lvl_g, lvl_b;
    logic       match, hit, wrap, last, close, close_q;

    logic [c_nb_img_pxls-1:0]  prev_addr_q, row_base_q, base, base_nxt, diff, diff_x;
    logic [c_nb_row-1:0]       row_q, row_cur, row_nxt;
    logic [c_nb_line_pxls-1:0] x;
    logic [11:0]               data_nxt;

    logic [c_nb_sum-1:0]      acc_x_q, acc_y_q, frm_x_q, frm_y_q, inc_x, inc_y, with_x, with_y;
    logic [c_nb_img_pxls-1:0] acc_cnt_q, frm_cnt_q, inc_cnt, with_cnt;

    logic [c_nb_sum-1:0]       dq_q, rem_q, div_y_q, dq_step, rem_step;
    logic [c_nb_sum:0]         rem_sh, div_ext;
    logic [c_nb_img_pxls-1:0]  div_cnt_q;
    logic [BitW-1:0]           bit_cnt_q;
    logic [c_nb_line_pxls-1:0] qx_q;
    logic [c_nb_row-1:0]       qy_q;
    logic                      quo_bit, bit_last, cnt_ok;
    logic                      load_x, div_run, save_x, save_y, publish;

    // Colour classification of the incoming pixel
    always_comb begin
        lvl_r = pxl_data[11:8];
        lvl_g = pxl_data[7:4];
        lvl_b = pxl_data[3:0];
        match = 1'b1;
        unique case (color_sel)
            2'b00:   match = (lvl_r >= thr_hi) && (lvl_g <= thr_lo) && (lvl_b <= thr_lo);
            2'b01:   match = (lvl_g >= thr_hi) && (lvl_r <= thr_lo) && (lvl_b <= thr_lo);
            2'b10:   match = (lvl_b >= thr_hi) && (lvl_r <= thr_lo) && (lvl_g <= thr_lo);
            default: match = 1'b1;
        endcase
        hit = pxl_we && match;
    end

    // Column/row of the incoming pixel and frame-close detection
    always_comb begin
        wrap    = pxl_addr < prev_addr_q;
        last    = pxl_addr == LastAddr;
        close   = pxl_we && (wrap || last);
        base    = wrap ? '0 : row_base_q;
        row_cur = wrap ? '0 : row_q;
        diff    = pxl_addr - base;
        if (diff >= Cols) begin
            diff_x   = diff - Cols;
            base_nxt = base + Cols;
            row_nxt  = row_cur + c_nb_row'(1);
        end else begin
            diff_x   = diff;
            base_nxt = base;
            row_nxt  = row_cur;
        end
        x = c_nb_line_pxls'(diff_x);
    end

    // Filtered pixel value, optionally with the centroid crosshair
    always_comb begin
        data_nxt = match ? pxl_data : 12'h000;
`ifdef CENTROID_MARK_EN
        if (centroid_valid && ((x == cx) || (row_nxt == cy))) begin
            data_nxt = 12'hFFF;
        end
`endif
    end

    // Accumulator contributions: with_* includes the current pixel
    always_comb begin
        inc_x    = hit ? c_nb_sum'(x) : '0;
        inc_y    = hit ? c_nb_sum'(row_nxt) : '0;
        inc_cnt  = hit ? c_nb_img_pxls'(1) : '0;
        with_x   = acc_x_q + inc_x;
        with_y   = acc_y_q + inc_y;
        with_cnt = acc_cnt_q + inc_cnt;
    end

    // Output stream and position tracker; a last-address close rewinds so address 0 is no wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_addr    <= '0;
            out_data    <= '0;
            out_we      <= 1'b0;
            prev_addr_q <= '0;
            row_base_q  <= '0;
            row_q       <= '0;
        end else begin
            out_we <= pxl_we;
            if (pxl_we) begin
                out_addr    <= pxl_addr;
                out_data    <= data_nxt;
                prev_addr_q <= last ? '0 : pxl_addr;
                row_base_q  <= last ? '0 : base_nxt;
                row_q       <= last ? '0 : row_nxt;
            end
        end
    end

    // Frame accumulators; a wrap pixel opens the new frame, a last-address pixel closes the old
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_x_q   <= '0;
            acc_y_q   <= '0;
            acc_cnt_q <= '0;
            frm_x_q   <= '0;
            frm_y_q   <= '0;
            frm_cnt_q <= '0;
            close_q   <= 1'b0;
        end else begin
            close_q <= close;
            if (pxl_we) begin
                if (wrap) begin
                    frm_x_q   <= acc_x_q;
                    frm_y_q   <= acc_y_q;
                    frm_cnt_q <= acc_cnt_q;
                    acc_x_q   <= inc_x;
                    acc_y_q   <= inc_y;
                    acc_cnt_q <= inc_cnt;
                end else if (last) begin
                    frm_x_q   <= with_x;
                    frm_y_q   <= with_y;
                    frm_cnt_q <= with_cnt;
                    acc_x_q   <= '0;
                    acc_y_q   <= '0;
                    acc_cnt_q <= '0;
                end else begin
                    acc_x_q   <= with_x;
                    acc_y_q   <= with_y;
                    acc_cnt_q <= with_cnt;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StAccum;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; any new close restarts the divide from the fresh snapshot
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAccum:   if (close_q) state_d = StDivX;
            StDivX:    if (close_q) state_d = StDivX;
                       else if (bit_last) state_d = StDivY;
            StDivY:    if (close_q) state_d = StDivX;
                       else if (bit_last) state_d = StPublish;
            StPublish: state_d = close_q ? StDivX : StAccum;
            default:   state_d = StAccum;
        endcase
    end

    // FSM control outputs
    always_comb begin
        bit_last = bit_cnt_q == BitW'(c_nb_sum - 1);
        load_x   = close_q;
        div_run  = ((state_q == StDivX) || (state_q == StDivY)) && !close_q;
        save_x   = div_run && (state_q == StDivX) && bit_last;
        save_y   = div_run && (state_q == StDivY) && bit_last;
        publish  = state_q == StPublish;
        cnt_ok   = div_cnt_q >= c_nb_img_pxls'(c_min_pxls);
    end

    // One restoring-divide step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        rem_sh   = {rem_q, dq_q[c_nb_sum-1]};
        div_ext  = (c_nb_sum + 1)'(div_cnt_q);
        quo_bit  = rem_sh >= div_ext;
        rem_step = quo_bit ? c_nb_sum'(rem_sh - div_ext) : c_nb_sum'(rem_sh);
        dq_step  = {dq_q[c_nb_sum-2:0], quo_bit};
    end

    // Divider datapath; iterations are suppressed for an empty frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dq_q      <= '0;
            rem_q     <= '0;
            div_y_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            qx_q      <= '0;
            qy_q      <= '0;
        end else if (load_x) begin
            dq_q      <= frm_x_q;
            rem_q     <= '0;
            div_y_q   <= frm_y_q;
            div_cnt_q <= frm_cnt_q;
            bit_cnt_q <= '0;
        end else if (div_run) begin
            bit_cnt_q <= bit_last ? '0 : bit_cnt_q + BitW'(1);
            if (save_x) begin
                qx_q  <= c_nb_line_pxls'(dq_step);
                dq_q  <= div_y_q;
                rem_q <= '0;
            end else if (div_cnt_q != '0) begin
                dq_q  <= dq_step;
                rem_q <= rem_step;
            end
            if (save_y) begin
                qy_q <= c_nb_row'(dq_step);
            end
        end
    end

    // Result publication; a sparse frame keeps the previous centroid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cx             <= '0;
            cy             <= '0;
            pxl_count      <= '0;
            centroid_valid <= 1'b0;
            centroid_upd   <= 1'b0;
        end else begin
            centroid_upd <= publish;
            if (publish) begin
                pxl_count      <= div_cnt_q;
                centroid_valid <= cnt_ok;
                if (cnt_ok) begin
                    cx <= qx_q;
                    cy <= qy_q;
                end
            end
        end
    end

endmodule
